sram_port_arbiter: RTL
======================

# sram_port_arbiter

Shares one single-port synchronous SRAM between the core's instruction-fetch port and data port, so that a unified memory can sit behind the CPU top level in place of separate instruction and data SRAMs. Each cycle it grants at most one requester, forwards that requester's address, write enables and write data to the SRAM, and returns read data with a one-cycle latency. The data port has priority, with a starvation guard for instruction fetch. The block raises per-port stall signals for the pipeline's hazard logic and keeps a contention counter for performance measurement.

## Interface
- MAX_DATA_RUN, default 4: the maximum number of consecutive data grants while an instruction request waits. Legal range is 1..15.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- inst_req  in  1  instruction read request
- inst_addr  in  32  instruction byte address
- inst_stall  out  1  inst_req is high this cycle and was not granted
- inst_rvalid  out  1  inst_rdata is valid; asserts for one cycle per granted fetch
- inst_rdata  out  32  fetch data
- data_req  in  1  data access request
- data_wen  in  4  byte write enables; 0 means a read
- data_addr  in  32  data byte address
- data_wdata  in  32  data to write
- data_stall  out  1  data_req is high this cycle and was not granted
- data_rvalid  out  1  data_rdata is valid; asserts only for granted reads
- data_rdata  out  32  load data
- sram_en  out  1  SRAM access strobe
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM byte address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid one cycle after an enabled read
- conflict_cnt  out  32  number of cycles in which inst_req and data_req were both high

## Operation
**Grant decision (combinational, same cycle)**
- No request: no grant. sram_en = 0, sram_wen = 0.
- Only one request: that requester is granted.
- Both requests: data is granted, unless run_cnt == MAX_DATA_RUN, in which case inst is granted.

**Starvation counter (run_cnt, 4-bit register)**
- Increments on each data grant while inst_req is high.
- Clears on any inst grant.
- Clears on any cycle in which inst_req is low.
- Never exceeds MAX_DATA_RUN.

**SRAM drive**
- Inst granted: sram_en = 1, sram_addr = inst_addr, sram_wen = 0, sram_wdata = 0.
- Data granted: sram_en = 1, sram_addr = data_addr, sram_wen = data_wen, sram_wdata = data_wdata.
- No grant: sram_addr and sram_wdata are 0.

**Stall outputs**
- inst_stall = inst_req & ~inst_grant.
- data_stall = data_req & ~data_grant.
- Both are purely combinational so the core can freeze the same cycle.

**Response tracking (resp_sel register: NONE / INST / DATA)**
- Loaded each cycle: INST on an inst grant; DATA on a data grant with data_wen == 0; NONE otherwise, including data writes.
- inst_rvalid = (resp_sel == INST). data_rvalid = (resp_sel == DATA).
- inst_rdata and data_rdata both present sram_rdata whenever the matching rvalid is high, and 0 otherwise.
- Data writes complete at grant and produce no response.

**Contention counter**
- conflict_cnt increments by 1 in each cycle where inst_req & data_req.
- It is a free-running 32-bit counter and wraps from 0xFFFFFFFF to 0.

## Timing
- Grant-to-response latency is exactly 1 cycle.
- The block is fully pipelined: a new grant may issue every cycle, including back-to-back grants to alternating ports.
- A requester must hold req, addr, wen and wdata stable while its stall is high. These inputs are sampled only in the grant cycle.
- Reset (asynchronous) forces resp_sel = NONE, run_cnt = 0 and conflict_cnt = 0. Every output therefore reads 0 during reset, except the combinational stalls, which follow inst_req and data_req with no grant issued.
- Reset asserted mid-operation drops any pending rvalid immediately. That response is lost, and the requester re-issues after reset.
- A data read immediately followed by a write to the same address returns the pre-write data, provided the SRAM is read-first.

## Test plan
- Single-port traffic: inst_req held for 3 cycles at addresses 0x0, 0x4 and 0x8, with data_req low. Required: inst_stall = 0 throughout, and inst_rvalid high in cycles 2–4 carrying SRAM words 0, 1 and 2.
- Collision: both requests high for one cycle, data_wen = 0, data_addr = 0x100. Required: data granted, inst_stall = 1, next cycle data_rvalid = 1 with mem[0x100], and conflict_cnt = 1.
- Starvation guard, MAX_DATA_RUN = 4: both requests held high continuously. Required grant sequence D,D,D,D,I,D,D,D,D,I. inst_stall is low only in cycles 5 and 10.
- Data write: data_wen = 4'b0011, data_addr = 0x20, data_wdata = 0xAABBCCDD over an SRAM word of 0x11223344. Required: sram_wen = 0011, no data_rvalid the next cycle, and a later read of 0x20 returns 0x1122CCDD.
- Counter wrap: conflict_cnt forced or preloaded to 0xFFFFFFFE, then 3 collision cycles. Required: conflict_cnt reads 0xFFFFFFFF, then 0, then 1.
- Mid-operation reset: rst pulsed while inst_rvalid is pending. Required: inst_rvalid goes low asynchronously, run_cnt and conflict_cnt return to 0, and normal grants resume on the first edge after rst deasserts.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - single-port SRAM arbiter between instruction fetch and data ports
module sram_port_arbiter #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_stall,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_stall,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic [31:0] conflict_cnt
);

  localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_t;

  resp_t       r_resp_sel;
  resp_t       w_resp_next;
  logic [3:0]  r_run_cnt;
  logic [3:0]  w_run_next;
  logic [31:0] r_conflict_cnt;
  logic        w_inst_grant;
  logic        w_data_grant;

  // Grant decision: data wins unless fetch has waited through MAX_DATA_RUN data grants;
  // no grant is issued while reset is held.
  always_comb begin
    w_inst_grant = 1'b0;
    w_data_grant = 1'b0;
    if (!rst) begin
      w_inst_grant = inst_req & (~data_req | (r_run_cnt == MAX_RUN));
      w_data_grant = data_req & ~w_inst_grant;
    end
  end

  // SRAM drive and stall outputs from the current grant.
  always_comb begin
    sram_en    = w_inst_grant | w_data_grant;
    sram_wen   = 4'b0000;
    sram_addr  = 32'd0;
    sram_wdata = 32'd0;
    if (w_inst_grant) begin
      sram_addr = inst_addr;
    end else if (w_data_grant) begin
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
    inst_stall = inst_req & ~w_inst_grant;
    data_stall = data_req & ~w_data_grant;
  end

  // Next response owner and next starvation count.
  always_comb begin
    w_resp_next = RESP_NONE;
    if (w_inst_grant) begin
      w_resp_next = RESP_INST;
    end else if (w_data_grant && (data_wen == 4'b0000)) begin
      w_resp_next = RESP_DATA;
    end
    w_run_next = r_run_cnt;
    if (!inst_req || w_inst_grant) begin
      w_run_next = 4'd0;
    end else if (w_data_grant && (r_run_cnt < MAX_RUN)) begin
      w_run_next = r_run_cnt + 4'd1;
    end
  end

  // State registers: response owner, starvation run, contention counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_sel     <= RESP_NONE;
      r_run_cnt      <= 4'd0;
      r_conflict_cnt <= 32'd0;
    end else begin
      r_resp_sel <= w_resp_next;
      r_run_cnt  <= w_run_next;
      if (inst_req && data_req) begin
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
    end
  end

  // Read data is steered to whichever port owns the response this cycle.
  always_comb begin
    inst_rvalid  = (r_resp_sel == RESP_INST);
    data_rvalid  = (r_resp_sel == RESP_DATA);
    inst_rdata   = inst_rvalid ? sram_rdata : 32'd0;
    data_rdata   = data_rvalid ? sram_rdata : 32'd0;
    conflict_cnt = r_conflict_cnt;
  end

endmodule
